// File: rtl/l1_l2_pkg.sv
// Shared types and default widths for the L1->L2 request port arbiter.
package l1_l2_pkg;

  localparam int unsigned TAG_W_DEF  = 18;
  localparam int unsigned IDX_W_DEF  = 8;
  localparam int unsigned LINE_W_DEF = 512;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_DW, GNT_DR} arb_state_t;

  typedef enum logic {REQ_I, REQ_D} req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick with a D-side lock override; purely combinational.
module rr_arb2
  import l1_l2_pkg::*;
(
  input  logic    i_req_i,
  input  logic    i_req_d,
  input  logic    i_lock_d,
  input  req_id_t i_last,
  output logic    o_valid,
  output req_id_t o_winner
);

  always_comb begin
    o_valid  = i_req_i | i_req_d;
    o_winner = REQ_I;
    if (i_lock_d && i_req_d) begin
      o_winner = REQ_D;
    end else if (i_req_i && i_req_d) begin
      o_winner = (i_last == REQ_I) ? REQ_D : REQ_I;
    end else if (i_req_d) begin
      o_winner = REQ_D;
    end
  end

endmodule

// File: rtl/l1_l2_port_arbiter.sv
// Shares the single L2 request port between L1I refills and L1D write-backs/refills,
// registering the granted request and steering L2's ready pulse back to the owner.
module l1_l2_port_arbiter
  import l1_l2_pkg::*;
#(
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_L1I_L2,
  input  logic [TAG_W-1:0]  tag_L1I_L2,
  input  logic [IDX_W-1:0]  index_L1I_L2,
  output logic              ready_L2_L1I,
  input  logic              read_L1D_L2,
  input  logic              write_L1D_L2,
  input  logic [TAG_W-1:0]  tag_L1D_L2,
  input  logic [IDX_W-1:0]  index_L1D_L2,
  input  logic [TAG_W-1:0]  write_tag_L1D_L2,
  input  logic [IDX_W-1:0]  write_index_L1D_L2,
  input  logic [LINE_W-1:0] write_data_L1D_L2,
  output logic              ready_L2_L1D,
  output logic              read_L1_L2,
  output logic              write_L1_L2,
  output logic [TAG_W-1:0]  tag_L1_L2,
  output logic [IDX_W-1:0]  index_L1_L2,
  output logic [LINE_W-1:0] write_data_L1_L2,
  input  logic              ready_L2_L1,
  output logic              timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t        r_state;
  req_id_t           r_rr_last;
  logic              r_d_lock;
  logic [CntW-1:0]   r_wait_cnt;
  logic              w_valid;
  req_id_t           w_winner;
  logic [CntW-1:0]   w_cnt_inc;
  logic              w_timeout_hit;

  rr_arb2 u_rr_arb2 (
    .i_req_i  (read_L1I_L2),
    .i_req_d  (read_L1D_L2 | write_L1D_L2),
    .i_lock_d (r_d_lock),
    .i_last   (r_rr_last),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  assign w_cnt_inc     = r_wait_cnt + CntW'(1);
  assign w_timeout_hit = (TIMEOUT != 0) && (32'(w_cnt_inc) == TIMEOUT);

  // Ready passes straight through to whichever L1 owns the current grant.
  assign ready_L2_L1I = ready_L2_L1 & (r_state == GNT_I);
  assign ready_L2_L1D = ready_L2_L1 & ((r_state == GNT_DW) || (r_state == GNT_DR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_rr_last        <= REQ_D;
      r_d_lock         <= 1'b0;
      r_wait_cnt       <= '0;
      timeout_err      <= 1'b0;
      read_L1_L2       <= 1'b0;
      write_L1_L2      <= 1'b0;
      tag_L1_L2        <= '0;
      index_L1_L2      <= '0;
      write_data_L1_L2 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (!read_L1D_L2) r_d_lock <= 1'b0;
          if (w_valid) begin
            r_rr_last <= w_winner;
            if (w_winner == REQ_I) begin
              r_state     <= GNT_I;
              read_L1_L2  <= 1'b1;
              tag_L1_L2   <= tag_L1I_L2;
              index_L1_L2 <= index_L1I_L2;
            end else if (write_L1D_L2) begin
              r_state          <= GNT_DW;
              write_L1_L2      <= 1'b1;
              tag_L1_L2        <= write_tag_L1D_L2;
              index_L1_L2      <= write_index_L1D_L2;
              write_data_L1_L2 <= write_data_L1D_L2;
            end else begin
              r_state     <= GNT_DR;
              read_L1_L2  <= 1'b1;
              tag_L1_L2   <= tag_L1D_L2;
              index_L1_L2 <= index_L1D_L2;
            end
          end
        end
        default: begin
          if (ready_L2_L1) begin
            r_state     <= IDLE;
            read_L1_L2  <= 1'b0;
            write_L1_L2 <= 1'b0;
            r_wait_cnt  <= '0;
            // A write-back locks the port for the D refill that normally follows it.
            if (r_state == GNT_DW) r_d_lock <= 1'b1;
            if (r_state == GNT_DR) r_d_lock <= 1'b0;
          end else begin
            if (r_wait_cnt != '1) r_wait_cnt <= w_cnt_inc;
            if (w_timeout_hit) timeout_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
